// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16 execute controller: opcode classes, flag indices,
// FSM states and PSR update masks.
`default_nettype none

package cr16_pkg;

  // 4-bit class codes: ext field in register form, op field in immediate form
  localparam logic [3:0] OP_REG  = 4'h0;
  localparam logic [3:0] C_WAIT  = 4'h0;
  localparam logic [3:0] C_AND   = 4'h1;
  localparam logic [3:0] C_OR    = 4'h2;
  localparam logic [3:0] C_XOR   = 4'h3;
  localparam logic [3:0] C_NOT   = 4'h4;
  localparam logic [3:0] C_ADD   = 4'h5;
  localparam logic [3:0] C_ADDU  = 4'h6;
  localparam logic [3:0] C_ADDC  = 4'h7;
  localparam logic [3:0] C_LSH   = 4'h8;
  localparam logic [3:0] C_SUB   = 4'h9;
  localparam logic [3:0] C_SUBC  = 4'hA;
  localparam logic [3:0] C_CMP   = 4'hB;
  localparam logic [3:0] C_RSH   = 4'hC;
  localparam logic [3:0] C_MOV   = 4'hD;
  localparam logic [3:0] C_MUL   = 4'hE;
  localparam logic [3:0] C_ASH   = 4'hF;

  localparam int FL_L = 4;
  localparam int FL_C = 3;
  localparam int FL_F = 2;
  localparam int FL_Z = 1;
  localparam int FL_N = 0;

  localparam logic [4:0] MASK_ARITH = 5'b01111;
  localparam logic [4:0] MASK_CMP   = 5'b10011;
  localparam logic [4:0] MASK_MUL   = 5'b01011;
  localparam logic [4:0] MASK_LOGIC = 5'b00011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_t;

  function automatic logic [4:0] flag_mask(input logic [3:0] code);
    logic [4:0] m;
    case (code)
      C_ADD, C_ADDU, C_ADDC, C_SUB, C_SUBC: m = MASK_ARITH;
      C_CMP:                                m = MASK_CMP;
      C_MUL:                                m = MASK_MUL;
      default:                              m = MASK_LOGIC;
    endcase
    return m;
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h2) || (op == 4'h3) || (op == 4'h4);
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == C_LSH) || (op == C_RSH) || (op == C_ASH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cr16_regfile.sv
// Register file: two combinational read ports, a debug read port and one
// synchronous write port, cleared by the asynchronous reset.
`default_nettype none

module cr16_regfile #(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  output logic [WIDTH-1:0]         rdata_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [WIDTH-1:0]         rdata_b,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see the stored value, so a read in the write cycle returns the old data
  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

`default_nettype wire

// File: rtl/cr16_exec_ctrl.sv
// CR16 issue/writeback controller: latches one instruction, drives the ALU
// operands, then writes back the result and merges ALU flags into the PSR.
`default_nettype none

module cr16_exec_ctrl
  import cr16_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [15:0]              instr,
  output logic [7:0]               alu_opcode,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic [4:0]               alu_flags,
  output logic [4:0]               psr,
  output logic                     done,
  output logic                     err,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int AW = $clog2(NREGS);

  state_t state, state_nxt;

  logic [15:0]      instr_q;
  logic [3:0]       op;
  logic [3:0]       ext;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rs;
  logic [7:0]       imm8;
  logic [3:0]       code;
  logic             illegal;
  logic             is_wait;
  logic             wb_en;
  logic [4:0]       mask;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic [WIDTH-1:0] opnd_b;
  logic [7:0]       opc_dec;

  assign op   = instr_q[15:12];
  assign rd   = instr_q[8 +: AW];
  assign ext  = instr_q[7:4];
  assign rs   = instr_q[0 +: AW];
  assign imm8 = instr_q[7:0];

  // Register form carries its class in ext, immediate form in op
  assign code    = (op == OP_REG) ? ext : op;
  assign illegal = is_illegal_op(op);
  assign is_wait = (op == OP_REG) && (ext == C_WAIT);
  assign wb_en   = !illegal && !is_wait && (code != C_CMP);
  assign mask    = flag_mask(code);

  always_comb begin
    opc_dec = {op, 4'h0};
    opnd_b  = {{(WIDTH-8){imm8[7]}}, imm8};
    if (op == OP_REG) begin
      opc_dec = {4'h0, ext};
      opnd_b  = rf_b;
    end else if (op == C_MOV) begin
      opnd_b  = {{(WIDTH-8){1'b0}}, imm8};
    end else if (is_shift_op(op)) begin
      opnd_b  = {{(WIDTH-4){1'b0}}, imm8[3:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_nxt = DECODE;
        end
      end
      DECODE:  state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      psr        <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if ((state == IDLE) && instr_valid) begin
        instr_q <= instr;
      end
      if (state == DECODE) begin
        alu_opcode <= opc_dec;
        alu_a      <= rf_a;
        alu_b      <= opnd_b;
      end
      if (state == EXEC) begin
        done <= 1'b1;
        err  <= illegal;
        // Only the class's flags are merged; ALU don't-care bits never reach psr
        if (!illegal && !is_wait) begin
          psr <= (psr & ~mask) | (alu_flags & mask);
        end
      end
    end
  end

  cr16_regfile #(
    .NREGS (NREGS),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       ((state == EXEC) && wb_en),
    .waddr    (rd),
    .wdata    (alu_result),
    .raddr_a  (rd),
    .rdata_a  (rf_a),
    .raddr_b  (rs),
    .rdata_b  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_cr16_exec_ctrl.sv
// Self-checking bench for cr16_exec_ctrl: stub ALU, directed sequence, then
// randomized instructions against an architectural reference model.
`default_nettype none

module tb_cr16_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        done;
  logic        err;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mr [16];
  logic [4:0]  mpsr;

  always #5 clk = ~clk;

  cr16_exec_ctrl #(.NREGS(16), .WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .psr         (psr),
    .done        (done),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Stub ALU: result plus all five flags, including bits the PSR must ignore
  function automatic logic [20:0] alu_model(input logic [7:0] opc, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [3:0]  k;
    logic [16:0] sum;
    logic [31:0] prod;
    logic [15:0] r;
    logic [4:0]  f;
    k    = (opc[7:4] != 4'h0) ? opc[7:4] : opc[3:0];
    sum  = {1'b0, a} + {1'b0, b};
    prod = a * b;
    case (k)
      4'h5, 4'h6, 4'h7:       r = a + b;
      4'h9, 4'hA, 4'hB:       r = a - b;
      4'hE:                   r = prod[15:0];
      4'h1:                   r = a & b;
      4'h2:                   r = a | b;
      4'h3:                   r = a ^ b;
      4'h4:                   r = ~b;
      4'hD:                   r = b;
      4'h8:                   r = a << b[3:0];
      4'hC:                   r = a >> b[3:0];
      4'hF:                   r = $unsigned($signed(a) >>> b[3:0]);
      default:                r = a;
    endcase
    f[4] = (b > a);
    if (k == 4'hE)                        f[3] = (prod[31:16] != 16'h0);
    else if (k == 4'h9 || k == 4'hA || k == 4'hB) f[3] = (a < b);
    else                                  f[3] = sum[16] & ~b[15];
    if (k == 4'h9 || k == 4'hA || k == 4'hB) f[2] = (a[15] != b[15]) && (r[15] != a[15]);
    else                                  f[2] = (a[15] == b[15]) && (sum[15] != a[15]);
    if (k == 4'hB) begin
      f[1] = (a == b);
      f[0] = ($signed(b) > $signed(a));
    end else begin
      f[1] = (r == 16'h0);
      f[0] = r[15];
    end
    return {f, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mr[i] = 16'h0;
    mpsr = 5'h0;
  endtask

  // Leaves the bench aligned to a falling edge with instr_valid low
  task automatic sweep_regs(input string tag);
    instr_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk(tag, dbg_data, mr[i]);
    end
    @(negedge clk);
  endtask

  // Starts in the low phase of an IDLE cycle; ends at the done cycle
  task automatic issue(input logic [15:0] w, input bit hold, input bit abort);
    logic [3:0]  op, rd, ext, rs, k;
    logic [7:0]  imm, eo;
    logic [15:0] ea, eb;
    logic [4:0]  m, f;
    logic [15:0] r;
    bit          ill, is_wait;
    op  = w[15:12]; rd = w[11:8]; ext = w[7:4]; rs = w[3:0]; imm = w[7:0];
    ill = (op >= 4'h1) && (op <= 4'h4);
    is_wait = (op == 4'h0) && (ext == 4'h0);
    ea  = mr[rd];
    if (op == 4'h0) begin
      eo = {4'h0, ext};
      eb = mr[rs];
      k  = ext;
    end else begin
      eo = {op, 4'h0};
      k  = op;
      if (op == 4'hD)                                eb = {8'h00, imm};
      else if (op == 4'h8 || op == 4'hC || op == 4'hF) eb = {12'h000, imm[3:0]};
      else                                           eb = {{8{imm[7]}}, imm};
    end
    {f, r} = alu_model(eo, ea, eb);
    case (k)
      4'h5, 4'h6, 4'h7, 4'h9, 4'hA: m = 5'b01111;
      4'hB:                         m = 5'b10011;
      4'hE:                         m = 5'b01011;
      default:                      m = 5'b00011;
    endcase

    instr_valid = 1'b1;
    instr       = w;
    chk("ready_idle", 16'(instr_ready), 16'h1);
    @(negedge clk);
    if (hold) instr = 16'($urandom);
    else      instr_valid = 1'b0;
    chk("ready_decode", 16'(instr_ready), 16'h0);
    chk("done_decode", 16'(done), 16'h0);
    @(negedge clk);
    chk("ready_exec", 16'(instr_ready), 16'h0);
    if (!ill) begin
      chk("alu_opcode", 16'(alu_opcode), 16'(eo));
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
    end
    if (abort) begin
      rst_n = 1'b0;
      #1;
      chk("abort_ready", 16'(instr_ready), 16'h1);
      chk("abort_done", 16'(done), 16'h0);
      chk("abort_err", 16'(err), 16'h0);
      chk("abort_psr", 16'(psr), 16'h0);
      chk("abort_opcode", 16'(alu_opcode), 16'h0);
      chk("abort_a", alu_a, 16'h0);
      chk("abort_b", alu_b, 16'h0);
      model_reset();
      @(negedge clk);
      instr_valid = 1'b0;
      rst_n = 1'b1;
      sweep_regs("abort_reg");
      return;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    if (!ill && !is_wait) begin
      mpsr = (mpsr & ~m) | (f & m);
      if (k != 4'hB) mr[rd] = r;
    end
    chk("done", 16'(done), 16'h1);
    chk("err", 16'(err), 16'(ill));
    chk("psr", 16'(psr), 16'(mpsr));
    dbg_addr = rd;
    #1;
    chk("reg_rd", dbg_data, mr[rd]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0;
    dbg_addr    = 4'h0;
    model_reset();
    @(negedge clk);
    chk("rst_ready", 16'(instr_ready), 16'h1);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_psr", 16'(psr), 16'h0);
    chk("rst_opcode", 16'(alu_opcode), 16'h0);
    chk("rst_a", alu_a, 16'h0);
    chk("rst_b", alu_b, 16'h0);
    rst_n = 1'b1;
    sweep_regs("rst_reg");

    // Directed sequence
    issue(16'hD17F, 1'b0, 1'b0);
    chk("movi_r1", dbg_data, 16'h007F);
    chk("movi_psr", 16'(psr), 16'h00);
    issue(16'h51FF, 1'b1, 1'b0);
    chk("addi_r1", dbg_data, 16'h007E);
    chk("addi_psr", 16'(psr), 16'h00);
    issue(16'hD2FF, 1'b0, 1'b0);
    issue(16'h8207, 1'b0, 1'b0);
    issue(16'h527F, 1'b0, 1'b0);
    chk("r2_7fff", dbg_data, 16'h7FFF);
    issue(16'hD301, 1'b0, 1'b0);
    issue(16'h0253, 1'b1, 1'b0);
    chk("add_r2", dbg_data, 16'h8000);
    chk("add_psr", 16'(psr), 16'h05);
    issue(16'h02B3, 1'b0, 1'b0);
    chk("cmp_r2", dbg_data, 16'h8000);
    chk("cmp_psr", 16'(psr), 16'h05);
    issue(16'h1234, 1'b1, 1'b0);
    chk("ill_err", 16'(err), 16'h1);
    chk("ill_psr", 16'(psr), 16'h05);
    issue(16'h0000, 1'b0, 1'b0);
    sweep_regs("dir_reg");

    // Randomized back-to-back traffic
    for (int n = 0; n < 80; n++) begin
      issue(16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    sweep_regs("rand_reg");

    issue(16'hD5AA, 1'b1, 1'b1);

    for (int n = 0; n < 30; n++) begin
      issue(16'($urandom), 1'b1, 1'b0);
    end
    sweep_regs("final_reg");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
